brp_pht_gshare: RTL
===================

Name: brp_pht_gshare

Overview:
- Parametrised successor to the single 2-bit bimodal predictor: a PC-indexed pattern history table (PHT) of CTR_BITS-wide saturating counters.
- An optional global history register (GHR) is XOR-folded into the index, giving gshare mode; GHR_BITS=0 degenerates to per-PC bimodal.
- Sits beside the fetch stage. It predicts combinationally for the fetch PC, and is trained and GHR-repaired by branch resolution in execute.

Parameters:
- PC_WIDTH, 32, PC width in bits.
- INDEX_BITS, 6, log2 of PHT depth (64 entries).
- CTR_BITS, 2, counter width; legal range 1..4.
- GHR_BITS, 6, global history length; legal range 0..INDEX_BITS; 0 = pure bimodal.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low.
- pred_valid  in  1  fetch is presenting a branch PC this cycle.
- pred_pc  in  PC_WIDTH  fetch PC.
- pred_taken  out  1  prediction for pred_pc.
- pred_index  out  INDEX_BITS  PHT index used; travels down the pipe with the branch.
- pred_ghr  out  max(GHR_BITS,1)  GHR value before this prediction's shift (checkpoint).
- upd_valid  in  1  a branch resolved this cycle.
- upd_index  in  INDEX_BITS  pred_index carried with that branch.
- upd_taken  in  1  actual outcome.
- upd_mispredict  in  1  predicted direction was wrong.
- upd_ghr  in  max(GHR_BITS,1)  pred_ghr checkpoint carried with that branch.

Behaviour:
- Reset, async on rst==0:
  - Every PHT counter = 2^(CTR_BITS-1)-1 (weakly not-taken; 0 when CTR_BITS=1).
  - GHR = 0.
  - pred_taken therefore reads 0 during and after reset.
- Index is combinational: pred_index = pred_pc[INDEX_BITS+1:2] XOR zero-extended GHR. When GHR_BITS=0 it is the PC slice only.
- Prediction is combinational, zero latency:
  - pred_taken = MSB of PHT[pred_index].
  - pred_ghr = current GHR.
  - Outputs are driven regardless of pred_valid; pred_valid gates state changes only.
- Training, when upd_valid=1 at the clock edge:
  - upd_taken=1: counter at PHT[upd_index] increments, saturating at 2^CTR_BITS-1.
  - upd_taken=0: counter decrements, saturating at 0.
  - Training does not depend on upd_mispredict.
- Read/write collision: a read and an update of the same index in the same cycle returns the pre-update (old) counter. There is no bypass.
- GHR update, evaluated in priority order:
  1. upd_valid && upd_mispredict: GHR <= {upd_ghr[GHR_BITS-2:0], upd_taken}. The repair wins over a same-cycle pred_valid, because that fetch is wrong-path.
  2. else pred_valid: GHR <= {GHR[GHR_BITS-2:0], pred_taken} (speculative shift).
  3. else GHR holds.
  - When GHR_BITS=1, the shift reduces to loading the single new bit.
  - When GHR_BITS=0, there is no GHR: pred_ghr drives 0 and upd_ghr is ignored.
- Correctly predicted updates never touch the GHR.
- Reset asserted mid-operation overrides all pending updates immediately. Updates presented while rst==0 are lost.
- Parameters outside the legal ranges must trigger an elaboration-time $error.

Decomposition:
- Package brp_pkg (imported alongside rv32i_types) holds:
  - ctr_t sizing helpers.
  - Functions sat_inc and sat_dec, parametrised by width.
  - Function ctr_init returning the weakly-not-taken value.
- Sub-module brp_ghr holds the GHR register:
  - Speculative shift-in and checkpoint-restore, with the priority above.
  - GHR_BITS parameter; generate-guarded for the 0 case.
- The PHT is a flop array in the top module; it is reset per entry, so no SRAM macro is used.

Test Plan:
- Reset check (INDEX_BITS=4, GHR_BITS=0): release rst, sweep pred_pc over 0x00..0x3C step 4 -> pred_taken=0 at all 16 indices; pred_ghr=0.
- Saturation (CTR_BITS=2, GHR_BITS=0): 3x upd taken at index 5 -> counter=3 and pred_taken=1 for PC 0x14; a 4th taken -> stays 3; then 2x not-taken -> counter=1, pred_taken=0; 2 more not-taken -> stays 0.
- Collision: pred_pc=0x14 and upd_index=5, taken, same cycle with counter=1 -> pred_taken=0 that cycle, 1 the next.
- Gshare index (INDEX_BITS=6, GHR_BITS=6): drive GHR to 0b101101 via 6 pred_valid cycles with pred_taken forced through training; pred_pc=0x40 -> pred_index=0x10^0x2D=0x3D.
- Mispredict repair: upd_mispredict=1, upd_ghr=0b000011, upd_taken=0, with pred_valid=1 in the same cycle -> next GHR=0b000110 and pred_valid is ignored.
- Async reset mid-stream: assert rst low between clock edges while upd_valid=1 -> counters and GHR return to init immediately with no clock edge; the pending update is dropped.

Source files
------------

// File: rtl/brp_pht_gshare_pkg.sv
// Shared types and saturating-counter helpers for the gshare/bimodal branch predictor.
// Counter helpers work on a 4-bit container; callers truncate to their CTR_BITS.
package brp_pkg;

  localparam int CTR_MAX_BITS = 4;

  typedef logic [CTR_MAX_BITS-1:0] ctr_max_t;

  typedef enum logic [1:0] {
    GHR_HOLD   = 2'd0,
    GHR_SPEC   = 2'd1,
    GHR_REPAIR = 2'd2
  } ghr_sel_e;

  // A zero-length history still needs a 1-bit port to carry a constant 0.
  function automatic int ghr_width(input int bits);
    return (bits <= 0) ? 1 : bits;
  endfunction

  function automatic ctr_max_t ctr_max(input int width);
    return ctr_max_t'((1 << width) - 1);
  endfunction

  function automatic ctr_max_t sat_inc(input ctr_max_t v, input int width);
    return (v >= ctr_max(width)) ? v : v + ctr_max_t'(1);
  endfunction

  function automatic ctr_max_t sat_dec(input ctr_max_t v);
    return (v == '0) ? v : v - ctr_max_t'(1);
  endfunction

  function automatic ctr_max_t ctr_init(input int width);
    return ctr_max_t'((1 << (width - 1)) - 1);
  endfunction

endpackage

// File: rtl/brp_pht_gshare_if.sv
// Fetch-side prediction and execute-side resolution signals of the branch predictor.
// The master drives PCs and resolutions; the slave (predictor) returns the prediction.
interface brp_pht_gshare_if
  import brp_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 6,
  parameter int GHR_BITS   = 6
);

  localparam int GW = ghr_width(GHR_BITS);

  logic                  pred_valid;
  logic [PC_WIDTH-1:0]   pred_pc;
  logic                  pred_taken;
  logic [INDEX_BITS-1:0] pred_index;
  logic [GW-1:0]         pred_ghr;

  logic                  upd_valid;
  logic [INDEX_BITS-1:0] upd_index;
  logic                  upd_taken;
  logic                  upd_mispredict;
  logic [GW-1:0]         upd_ghr;

  modport master (
    output pred_valid, pred_pc,
    output upd_valid, upd_index, upd_taken, upd_mispredict, upd_ghr,
    input  pred_taken, pred_index, pred_ghr
  );

  modport slave (
    input  pred_valid, pred_pc,
    input  upd_valid, upd_index, upd_taken, upd_mispredict, upd_ghr,
    output pred_taken, pred_index, pred_ghr
  );

endinterface

// File: rtl/brp_pht_gshare_ghr.sv
// Global history register: speculative shift-in at fetch, checkpoint restore on mispredict.
// With GHR_BITS=0 there is no register and the output is constant zero.
module brp_ghr
  import brp_pkg::*;
#(
  parameter  int GHR_BITS = 6,
  localparam int GW       = ghr_width(GHR_BITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spec_valid_i,
  input  logic          spec_bit_i,
  input  logic          repair_valid_i,
  input  logic [GW-1:0] repair_ghr_i,
  input  logic          repair_bit_i,
  output logic [GW-1:0] ghr_o
);

  ghr_sel_e sel;

  // A repair wins over a same-cycle fetch, which is on the wrong path.
  always_comb begin
    sel = GHR_HOLD;
    if (repair_valid_i)    sel = GHR_REPAIR;
    else if (spec_valid_i) sel = GHR_SPEC;
  end

  if (GHR_BITS == 0) begin : g_no_ghr
    logic unused_ok;
    assign unused_ok = ^{clk, rst, sel, spec_bit_i, repair_ghr_i, repair_bit_i};
    assign ghr_o     = '0;
  end else begin : g_ghr
    logic [GW-1:0] ghr_q, ghr_d;

    // The left shift drops the oldest bit, so a 1-bit history simply loads the new bit.
    always_comb begin
      case (sel)
        GHR_REPAIR: ghr_d = (repair_ghr_i << 1) | GW'(repair_bit_i);
        GHR_SPEC:   ghr_d = (ghr_q << 1) | GW'(spec_bit_i);
        default:    ghr_d = ghr_q;
      endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) ghr_q <= '0;
      else      ghr_q <= ghr_d;
    end

    assign ghr_o = ghr_q;
  end

endmodule

// File: rtl/brp_pht_gshare.sv
// PC-indexed pattern history table of saturating counters, optionally gshare-indexed.
// Predicts combinationally for the fetch PC; trained and GHR-repaired by execute.
module brp_pht_gshare
  import brp_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int GHR_BITS   = 6
) (
  input logic              clk,
  input logic              rst,
  brp_pht_gshare_if.slave  bus
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam int GW    = ghr_width(GHR_BITS);

  if (CTR_BITS < 1 || CTR_BITS > CTR_MAX_BITS) begin : g_bad_ctr
    $error("brp_pht_gshare: CTR_BITS=%0d outside 1..%0d", CTR_BITS, CTR_MAX_BITS);
  end
  if (GHR_BITS < 0 || GHR_BITS > INDEX_BITS) begin : g_bad_ghr
    $error("brp_pht_gshare: GHR_BITS=%0d outside 0..INDEX_BITS(%0d)", GHR_BITS, INDEX_BITS);
  end
  if (PC_WIDTH < INDEX_BITS + 2) begin : g_bad_pc
    $error("brp_pht_gshare: PC_WIDTH=%0d too narrow for INDEX_BITS=%0d", PC_WIDTH, INDEX_BITS);
  end

  logic [CTR_BITS-1:0]   pht_q [DEPTH];
  logic [CTR_BITS-1:0]   pht_d [DEPTH];
  logic [GW-1:0]         ghr;
  logic [INDEX_BITS-1:0] pred_index;
  logic                  pred_taken;
  logic                  unused_pc;

  // Word-aligned PCs: bits [1:0] never select an entry.
  assign pred_index = bus.pred_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr);
  assign pred_taken = pht_q[pred_index][CTR_BITS-1];
  assign unused_pc  = ^bus.pred_pc;

  assign bus.pred_taken = pred_taken;
  assign bus.pred_index = pred_index;
  assign bus.pred_ghr   = ghr;

  // NOTE: every entry of pht_d gets a default before the conditional write, so no latch is inferred.
  always_comb begin
    pht_d = pht_q;
    if (bus.upd_valid) begin
      pht_d[bus.upd_index] = bus.upd_taken
        ? CTR_BITS'(sat_inc(ctr_max_t'(pht_q[bus.upd_index]), CTR_BITS))
        : CTR_BITS'(sat_dec(ctr_max_t'(pht_q[bus.upd_index])));
    end
  end

  // NOTE: the table is a flop array reset entry by entry; an SRAM could not give a defined start state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) pht_q[i] <= CTR_BITS'(ctr_init(CTR_BITS));
    end else begin
      pht_q <= pht_d;
    end
  end

  brp_ghr #(
    .GHR_BITS (GHR_BITS)
  ) u_ghr (
    .clk            (clk),
    .rst            (rst),
    .spec_valid_i   (bus.pred_valid),
    .spec_bit_i     (pred_taken),
    .repair_valid_i (bus.upd_valid & bus.upd_mispredict),
    .repair_ghr_i   (bus.upd_ghr),
    .repair_bit_i   (bus.upd_taken),
    .ghr_o          (ghr)
  );

endmodule
